// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one combinational datapath
//               ALU between two requesters (0 = execute stage, 1 = address /
//               auxiliary unit). The winning operands are registered into the
//               ALU, the ALU result is captured one cycle later and held on a
//               valid/ready response channel until the winner accepts it.
//
//               Optional feature macro: ALU_ARB_TIMEOUT_EN
//                 defined   : a response left unaccepted for TIMEOUT_CYCLES
//                             cycles is dropped and timeout_err pulses once.
//                 undefined : the response waits indefinitely and
//                             timeout_err is tied low.
//
// Ports       : clk, rst                 clock / synchronous active-high reset
//               req_valid/req_ready      per-requester request handshake
//               req{0,1}_fields/rs/rt    operands {opcode,ALU_control,shamt,imm}
//               resp_valid/resp_ready    per-requester response handshake
//               resp_result/resp_branch  captured ALU outputs
//               alu_fields/alu_rs/alu_rt registered operands to the ALU
//               alu_result/alu_sig_branch ALU outputs
//               busy                     state is not IDLE
//               timeout_err              one-cycle pulse on a dropped response
//
// Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [32:0] req0_fields,
    input  logic [31:0] req0_rs,
    input  logic [31:0] req0_rt,
    input  logic [32:0] req1_fields,
    input  logic [31:0] req1_rs,
    input  logic [31:0] req1_rt,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_branch,
    output logic [32:0] alu_fields,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rt,
    input  logic [31:0] alu_result,
    input  logic        alu_sig_branch,
    output logic        busy,
    output logic        timeout_err
);

    // Elaboration-time sanity check on the timeout length (8-bit counter).
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("alu_arbiter: TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state_q, w_state_d;
    logic        r_last_q,  w_last_d;     // requester granted most recently
    logic        r_win_q,   w_win_d;      // owner of the operation in flight
    logic [32:0] r_fields_q, w_fields_d;
    logic [31:0] r_rs_q,    w_rs_d;
    logic [31:0] r_rt_q,    w_rt_d;
    logic [31:0] r_result_q, w_result_d;
    logic        r_branch_q, w_branch_d;
    logic        r_terr_q,  w_terr_d;

    logic        w_winner;
    logic        w_accept;
    logic        w_done;
    logic        w_drop;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_winner = 1'b0;
        case (req_valid)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last_q;
            default: w_winner = 1'b0;
        endcase
    end

    assign w_accept  = (r_state_q == ST_IDLE) && (req_valid != 2'b00);
    assign req_ready = w_accept ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

    // Only the owner's resp_ready completes the handshake.
    assign w_done = (r_state_q == ST_RESP) && resp_ready[r_win_q];

`ifdef ALU_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_cnt_q, w_cnt_d;
    logic [7:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt_q + 8'd1;

    // Counts RESP cycles without a handshake; cleared while in EXEC so it
    // starts at zero on RESP entry.
    always_comb begin
        w_cnt_d = r_cnt_q;
        w_drop  = 1'b0;
        if (r_state_q == ST_EXEC) begin
            w_cnt_d = 8'd0;
        end else if ((r_state_q == ST_RESP) && !w_done) begin
            w_cnt_d = w_cnt_inc;
            if (w_cnt_inc == C_TIMEOUT) begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= 8'd0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end
`else
    assign w_drop = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state_q;
        w_last_d   = r_last_q;
        w_win_d    = r_win_q;
        w_fields_d = r_fields_q;
        w_rs_d     = r_rs_q;
        w_rt_d     = r_rt_q;
        w_result_d = r_result_q;
        w_branch_d = r_branch_q;
        w_terr_d   = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_fields_d = w_winner ? req1_fields : req0_fields;
                    w_rs_d     = w_winner ? req1_rs     : req0_rs;
                    w_rt_d     = w_winner ? req1_rt     : req0_rt;
                    w_win_d    = w_winner;
                    w_last_d   = w_winner;
                    w_state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_result_d = alu_result;
                w_branch_d = alu_sig_branch;
                w_state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (w_done) begin
                    w_state_d = ST_IDLE;
                end else if (w_drop) begin
                    w_state_d = ST_IDLE;
                    w_terr_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_last_q   <= 1'b1;
            r_win_q    <= 1'b0;
            r_fields_q <= 33'd0;
            r_rs_q     <= 32'd0;
            r_rt_q     <= 32'd0;
            r_result_q <= 32'd0;
            r_branch_q <= 1'b0;
            r_terr_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_last_q   <= w_last_d;
            r_win_q    <= w_win_d;
            r_fields_q <= w_fields_d;
            r_rs_q     <= w_rs_d;
            r_rt_q     <= w_rt_d;
            r_result_q <= w_result_d;
            r_branch_q <= w_branch_d;
            r_terr_q   <= w_terr_d;
        end
    end

    assign resp_valid  = (r_state_q == ST_RESP) ? (r_win_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result = r_result_q;
    assign resp_branch = r_branch_q;
    assign alu_fields  = r_fields_q;
    assign alu_rs      = r_rs_q;
    assign alu_rt      = r_rt_q;
    assign busy        = (r_state_q != ST_IDLE);
    assign timeout_err = r_terr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A transaction-level model
//               predicts every output each cycle; directed vectors pin the
//               model with hand-computed values. A small behavioural ALU
//               stands in for the real datapath ALU.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [32:0] req0_fields = '0;
    logic [31:0] req0_rs = '0;
    logic [31:0] req0_rt = '0;
    logic [32:0] req1_fields = '0;
    logic [31:0] req1_rs = '0;
    logic [31:0] req1_rt = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] resp_result;
    logic        resp_branch;
    logic [32:0] alu_fields;
    logic [31:0] alu_rs;
    logic [31:0] alu_rt;
    logic [31:0] alu_result;
    logic        alu_sig_branch;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_fields(req0_fields), .req0_rs(req0_rs), .req0_rt(req0_rt),
        .req1_fields(req1_fields), .req1_rs(req1_rs), .req1_rt(req1_rt),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_branch(resp_branch),
        .alu_fields(alu_fields), .alu_rs(alu_rs), .alu_rt(alu_rt),
        .alu_result(alu_result), .alu_sig_branch(alu_sig_branch),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Behavioural ALU: returns {branch, result}.
    function automatic logic [32:0] alu_fn(input logic [32:0] f,
                                           input logic [31:0] rs,
                                           input logic [31:0] rt);
        logic [5:0]  op;
        logic [5:0]  ctl;
        logic [4:0]  sh;
        logic [31:0] sx;
        logic [31:0] res;
        logic        br;
        op  = f[32:27];
        ctl = f[26:21];
        sh  = f[20:16];
        sx  = {{16{f[15]}}, f[15:0]};
        res = 32'd0;
        br  = 1'b0;
        case (op)
            6'b101011, 6'b100011, 6'b001000: res = rs + sx;
            6'b001101: res = rs | {16'd0, f[15:0]};
            6'b000100: begin res = rs - rt; br = (rs == rt); end
            6'b000000: begin
                case (ctl)
                    6'b100000: res = rs + rt;
                    6'b100010: res = rs - rt;
                    6'b100100: res = rs & rt;
                    6'b100101: res = rs | rt;
                    6'b000000: res = rt << sh;
                    default:   res = 32'd0;
                endcase
            end
            default: res = 32'd0;
        endcase
        return {br, res};
    endfunction

    assign {alu_sig_branch, alu_result} = alu_fn(alu_fields, alu_rs, alu_rt);

    function automatic logic [32:0] mk(input logic [5:0] op, input logic [5:0] ctl,
                                       input logic [4:0] sh, input logic [15:0] imm);
        return {op, ctl, sh, imm};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_known = 1'b0;
    int          m_age   = 0;     // 0 idle, 1 operands in ALU, 2+ response pending
    int          m_rc    = 0;     // response cycles waited
    bit          m_last  = 1'b1;
    bit          m_owner = 1'b0;
    logic [32:0] m_f     = '0;
    logic [31:0] m_rs    = '0;
    logic [31:0] m_rt    = '0;
    logic [31:0] m_res   = '0;
    logic        m_br    = 1'b0;
    logic        m_terr  = 1'b0;

    task automatic monitor();
        bit   w;
        logic [1:0] e_rdy;
        forever begin
            @(negedge clk);
            e_rdy = 2'b00;
            w = 1'b0;
            if (m_age == 0 && req_valid != 2'b00) begin
                w = (req_valid == 2'b11) ? !m_last : req_valid[1];
                e_rdy = w ? 2'b10 : 2'b01;
            end
            if (m_known) begin
                chk("m_req_ready",  req_ready, e_rdy);
                chk("m_resp_valid", resp_valid, (m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
                chk("m_resp_result", resp_result, m_res);
                chk("m_resp_branch", resp_branch, m_br);
                chk("m_alu_fields", alu_fields, m_f);
                chk("m_alu_rs", alu_rs, m_rs);
                chk("m_alu_rt", alu_rt, m_rt);
                chk("m_busy", busy, m_age != 0);
                chk("m_timeout_err", timeout_err, m_terr);
            end
            if (rst) begin
                m_known = 1'b1; m_age = 0; m_rc = 0; m_last = 1'b1; m_owner = 1'b0;
                m_f = '0; m_rs = '0; m_rt = '0; m_res = '0; m_br = 1'b0; m_terr = 1'b0;
            end else begin
                m_terr = 1'b0;
                if (m_age == 0) begin
                    if (req_valid != 2'b00) begin
                        m_owner = w;
                        m_last  = w;
                        m_f  = w ? req1_fields : req0_fields;
                        m_rs = w ? req1_rs : req0_rs;
                        m_rt = w ? req1_rt : req0_rt;
                        m_age = 1;
                    end
                end else if (m_age == 1) begin
                    {m_br, m_res} = alu_fn(m_f, m_rs, m_rt);
                    m_age = 2;
                    m_rc  = 0;
                end else begin
                    if (resp_ready[m_owner]) begin
                        m_age = 0;
                    end else begin
                        m_rc++;
`ifdef ALU_ARB_TIMEOUT_EN
                        if (m_rc == TMO) begin
                            m_age  = 0;
                            m_terr = 1'b1;
                        end
`endif
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stimulus();
        int prev;
        bit got;
        int rv;
        int pulses;
        // ---- reset ----
        step(); step();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_alu_rs", alu_rs, 32'd0);
        chk("rst_timeout_err", timeout_err, 1'b0);

        // ---- requester 0 alone: sw rs=15 imm=19 -> 34 ----
        step();
        rst = 1'b0;
        req0_fields = mk(6'b101011, 6'd0, 5'd0, 16'd19);
        req0_rs = 32'd15; req0_rt = 32'd12;
        req_valid = 2'b01;
        @(negedge clk);
        chk("sw_req_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        @(negedge clk);
        chk("sw_exec_busy", busy, 1'b1);
        chk("sw_exec_resp_valid", resp_valid, 2'b00);
        step(); resp_ready = 2'b01;
        @(negedge clk);
        chk("sw_resp_valid", resp_valid, 2'b01);
        chk("sw_result", resp_result, 32'd34);
        step();
        @(negedge clk);
        chk("sw_done_busy", busy, 1'b0);

        // ---- round robin with both valid ----
        step(); resp_ready = 2'b00; rst = 1'b1;
        step(); rst = 1'b0;
        req0_fields = mk(6'b001000, 6'd0, 5'd0, 16'd14); req0_rs = 32'd23; req0_rt = 32'd0;
        req1_fields = mk(6'b001000, 6'd0, 5'd0, 16'd8);  req1_rs = 32'd1;  req1_rt = 32'd0;
        req_valid = 2'b11; resp_ready = 2'b11;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin got = 1'b1; break; end
            end
            if (!got) begin
                chk("rr_grant_timeout", 1'b0, 1'b1);
            end else begin
                chk("rr_grant_order", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
                if (g > 0) chk("rr_grant_spacing", cyc - prev, 3);
                prev = cyc;
                @(negedge clk);
                @(negedge clk);
                chk("rr_resp_valid", resp_valid, (g % 2 == 0) ? 2'b01 : 2'b10);
                chk("rr_result", resp_result, (g % 2 == 0) ? 32'd37 : 32'd9);
            end
        end
        step(); req_valid = 2'b00; resp_ready = 2'b00;

        // ---- backpressure: r0 sub 100-58=42, r1 beq 7==7 waits ----
        req0_fields = mk(6'b000000, 6'b100010, 5'd0, 16'd0); req0_rs = 32'd100; req0_rt = 32'd58;
        req1_fields = mk(6'b000100, 6'd0, 5'd0, 16'd3);      req1_rs = 32'd7;   req1_rt = 32'd7;
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_req_ready", req_ready, 2'b01);
        step(); req_valid = 2'b10;
        step();
        @(negedge clk);
        chk("bp_resp_valid", resp_valid, 2'b01);
        chk("bp_result", resp_result, 32'd42);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 4) resp_ready = 2'b10;   // non-owner ready must be ignored
            @(negedge clk);
            chk("bp_hold_valid", resp_valid, 2'b01);
            chk("bp_hold_result", resp_result, 32'd42);
            chk("bp_hold_req_ready", req_ready, 2'b00);
        end
        step(); resp_ready = 2'b01;
        @(negedge clk);
        chk("bp_hs_req_ready", req_ready, 2'b00);
        step(); resp_ready = 2'b00;
        @(negedge clk);
        chk("bp_r1_granted", req_ready, 2'b10);
        chk("bp_idle_busy", busy, 1'b0);
        step(); req_valid = 2'b00;
        step();
        @(negedge clk);
        chk("beq_resp_valid", resp_valid, 2'b10);
        chk("beq_branch", resp_branch, 1'b1);
        chk("beq_result", resp_result, 32'd0);
        step(); resp_ready = 2'b10;
        step(); resp_ready = 2'b00;

        // ---- reset in the middle of a response: ori 0x0F|0xF0 ----
        req0_fields = mk(6'b001101, 6'd0, 5'd0, 16'h00F0); req0_rs = 32'h0F; req0_rt = 32'd0;
        req_valid = 2'b01;
        step(); req_valid = 2'b00;
        step();
        @(negedge clk);
        chk("ori_result", resp_result, 32'hFF);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 2'b00);
        chk("mid_rst_resp_valid", resp_valid, 2'b00);
        chk("mid_rst_result", resp_result, 32'd0);
        chk("mid_rst_branch", resp_branch, 1'b0);
        chk("mid_rst_fields", alu_fields, 33'd0);
        chk("mid_rst_rs", alu_rs, 32'd0);
        chk("mid_rst_rt", alu_rt, 32'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_terr", timeout_err, 1'b0);

        // ---- unaccepted response: addi 5 + (-2) = 3 ----
        step();
        req0_fields = mk(6'b001000, 6'd0, 5'd0, 16'hFFFE); req0_rs = 32'd5;
        req_valid = 2'b01;
        step(); req_valid = 2'b00;
        rv = 0; pulses = 0;
`ifdef ALU_ARB_TIMEOUT_EN
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) rv++;
            if (timeout_err) pulses++;
        end
        chk("tmo_resp_cycles", rv, TMO);
        chk("tmo_pulses", pulses, 1);
        chk("tmo_busy", busy, 1'b0);
`else
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) rv++;
            if (timeout_err) pulses++;
        end
        chk("wait_resp_cycles_ge100", rv >= 100, 1'b1);
        chk("wait_no_pulses", pulses, 0);
        chk("wait_busy", busy, 1'b1);
        chk("wait_result", resp_result, 32'd3);
`endif
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        step();
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #400000;
                total++;
                bad++;
                $display("FAIL watchdog actual=timeout expected=completion");
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single datapath `ALU` between two requesters: port 0 is the execute stage and port 1 is the address/auxiliary unit. The block arbitrates round-robin, registers the winning operands into the ALU, and captures `ALU_result`/`sig_branch` one cycle later. It then holds the result on a valid/ready response channel until the winner accepts it. At top level it sits between the requesters and the `ALU` instance and owns all ALU input ports.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles in RESP before the response is dropped. Used only with `ALU_ARB_TIMEOUT_EN`; minimum value 1.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  2  bit N: requester N has an operation pending
- `req_ready`  out  2  bit N: requester N's operation accepted this cycle
- `req0_fields`  in  33  packed {opcode[5:0], ALU_control[5:0], shamt[4:0], immediate[15:0]}
- `req0_rs`  in  32  rs_content, requester 0
- `req0_rt`  in  32  rt_content, requester 0
- `req1_fields`  in  33  same packing, requester 1
- `req1_rs`  in  32  rs_content, requester 1
- `req1_rt`  in  32  rt_content, requester 1
- `resp_valid`  out  2  bit N: result for requester N is available
- `resp_ready`  in  2  bit N: requester N takes the result
- `resp_result`  out  32  captured ALU_result
- `resp_branch`  out  1  captured sig_branch
- `alu_fields`  out  33  to ALU opcode/ALU_control/shamt/immediate, same packing as the request fields
- `alu_rs`  out  32  to ALU rs_content
- `alu_rt`  out  32  to ALU rt_content
- `alu_result`  in  32  from ALU ALU_result
- `alu_sig_branch`  in  1  from ALU sig_branch
- `busy`  out  1  high whenever state is not IDLE
- `timeout_err`  out  1  one-cycle pulse when a response is dropped

## Operation
- States are IDLE, EXEC, RESP.
- **IDLE**
  - Winner selection: a single valid requester wins. If both are valid, the requester not granted last wins. The `last` pointer resets to 1, so requester 0 wins the first tie.
  - `req_ready[w]` is combinational: `state==IDLE && req_valid[w] && winner==w`. At most one bit is high.
  - On acceptance: latch `reqW_fields`/`rs`/`rt` into the operand registers, store `w`, set `last<=w`, go to EXEC.
- **EXEC**: the ALU inputs are driven from the operand registers. At the edge, capture `alu_result` and `alu_sig_branch` into the result registers and go to RESP.
- **RESP**
  - `resp_valid[w]=1`; `resp_result`/`resp_branch` are stable.
  - `resp_ready[w]=1` at an edge completes the handshake; go to IDLE.
  - `resp_ready` of the non-granted bit is ignored.
  - `req_valid` is ignored outside IDLE. Requesters must hold their fields stable until `req_ready`.
  - A request that deasserts before acceptance has no effect.
- The operand registers (`alu_*`) hold their last values in all states; there is no zeroing after an operation.
- Reset at any point, including mid-operation:
  - state goes to IDLE, `last` to 1;
  - all operand/result registers go to 0;
  - the pending response is discarded with no `timeout_err`.
- Output reset values are all 0: `req_ready`, `resp_valid`, `resp_result`, `resp_branch`, `alu_fields`, `alu_rs`, `alu_rt`, `busy`, `timeout_err`.

## Timing
- Accept edge T, EXEC cycle T+1, result registered at edge T+2, `resp_valid` high from cycle T+2.
- With `resp_ready` already high at T+2: handshake at edge T+3, and the next request can be accepted in cycle T+3.
- Minimum 3 cycles per operation, no overlap between operations.
- The ALU is purely combinational and must settle within one cycle from the operand registers.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on RESP entry and increments each cycle in RESP without the handshake.
  - When the counter reaches `TIMEOUT_CYCLES`, the block drops the response and goes to IDLE.
  - `timeout_err` is 1 for the following cycle only.
- Not defined: RESP waits indefinitely, `timeout_err` is tied to 0, and no counter is built.

## Test plan
- Reset, then pulse `rst` during RESP: every output reads 0 the cycle after the reset edge, and `busy`=0.
- Requester 0 alone, sw opcode 101011, rs=15, rt=12, imm=19 with the real ALU: `req_ready`=01 at T, `resp_valid`=01 at T+2, `resp_result`=34.
- Both requesters valid continuously, `resp_ready`=11: grant order 0,1,0,1 with one grant every 3 cycles; results follow each requester's own operands (rs=23, imm=14 gives 37; rs=1, imm=8 gives 9).
- Hold `resp_ready`=00 for 5 cycles with requester 1 valid throughout: `resp_valid` stays set, `result` stays stable, `req_ready` stays 00; requester 1 is granted in the cycle after the handshake.
- With `ALU_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `resp_ready` held 0: after 4 RESP cycles `busy` drops and `timeout_err` pulses exactly once; without the macro the block stays in RESP for at least 100 cycles.
